// File: rtl/mem_access_stage.sv
// MEM pipeline stage: forwards ALU results and runs single-outstanding data-memory
// loads/stores with a bounded wait, retiring one result per op to write-back.
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clock_signal,
  input  logic        reset_signal_n,
  input  logic        execute_valid,
  input  logic [31:0] execute_alu_out,
  input  logic [31:0] execute_register_b_data,
  input  logic [4:0]  execute_dest_register_address,
  input  logic        execute_mem_read_ctrl,
  input  logic        execute_mem_write_ctrl,
  input  logic        execute_register_write_ctrl,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        back_valid,
  output logic [31:0] back_data,
  output logic [4:0]  back_dest_address,
  output logic        back_register_write_ctrl,
  output logic        memory_stall_ctrl,
  output logic        mem_fault
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned CNT_W  = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  state_e              state_q;
  logic                req_q;
  logic                we_q;
  logic [DATA_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [REG_W-1:0]    dest_q;
  logic                wctrl_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic                back_valid_q;
  logic [DATA_W-1:0]   back_data_q;
  logic [REG_W-1:0]    back_dest_q;
  logic                back_wctrl_q;
  logic                fault_q;

  logic                mem_op;
  logic                timeout_hit;

  // Request classification and wait-counter arithmetic.
  always_comb begin
    mem_op      = execute_valid & (execute_mem_read_ctrl | execute_mem_write_ctrl);
    cnt_d       = cnt_q + CNT_W'(1);
    timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
  end

  // Stall is held low while in reset so every output reads zero then.
  always_comb begin
    memory_stall_ctrl = reset_signal_n &
                        ((state_q == ST_WAIT) | ((state_q == ST_IDLE) & mem_op));
  end

  always_ff @(posedge clock_signal or negedge reset_signal_n) begin
    if (!reset_signal_n) begin
      state_q      <= ST_IDLE;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      dest_q       <= '0;
      wctrl_q      <= 1'b0;
      cnt_q        <= '0;
      back_valid_q <= 1'b0;
      back_data_q  <= '0;
      back_dest_q  <= '0;
      back_wctrl_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      back_valid_q <= 1'b0;
      back_wctrl_q <= 1'b0;
      fault_q      <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (mem_op) begin
            addr_q  <= execute_alu_out;
            wdata_q <= execute_register_b_data;
            we_q    <= execute_mem_write_ctrl;
            dest_q  <= execute_dest_register_address;
            wctrl_q <= execute_register_write_ctrl;
            req_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= ST_WAIT;
          end else if (execute_valid) begin
            back_valid_q <= 1'b1;
            back_data_q  <= execute_alu_out;
            back_dest_q  <= execute_dest_register_address;
            back_wctrl_q <= execute_register_write_ctrl;
          end
        end
        ST_WAIT: begin
          // Ack takes priority over the timeout on the same edge.
          if (dmem_ack) begin
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            back_valid_q <= 1'b1;
            back_dest_q  <= dest_q;
            if (we_q) begin
              back_data_q  <= addr_q;
              back_wctrl_q <= 1'b0;
            end else begin
              back_data_q  <= dmem_rdata;
              back_wctrl_q <= wctrl_q;
            end
            state_q <= ST_IDLE;
          end else if (timeout_hit) begin
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            fault_q      <= 1'b1;
            back_valid_q <= 1'b1;
            back_dest_q  <= dest_q;
            state_q      <= ST_IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dmem_req                 = req_q;
  assign dmem_we                  = we_q;
  assign dmem_addr                = addr_q;
  assign dmem_wdata               = wdata_q;
  assign back_valid               = back_valid_q;
  assign back_data                = back_data_q;
  assign back_dest_address        = back_dest_q;
  assign back_register_write_ctrl = back_wctrl_q;
  assign mem_fault                = fault_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed vector table, reset corner sequences and
// randomized ops checked against a transaction-level model.
module tb_mem_access_stage;

  localparam int TIMEOUT = 16;

  logic        clk;
  logic        rst_n;
  logic        execute_valid;
  logic [31:0] execute_alu_out;
  logic [31:0] execute_register_b_data;
  logic [4:0]  execute_dest_register_address;
  logic        execute_mem_read_ctrl;
  logic        execute_mem_write_ctrl;
  logic        execute_register_write_ctrl;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        back_valid;
  logic [31:0] back_data;
  logic [4:0]  back_dest_address;
  logic        back_register_write_ctrl;
  logic        memory_stall_ctrl;
  logic        mem_fault;

  int errors = 0;
  int checks = 0;

  mem_access_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clock_signal                  (clk),
    .reset_signal_n                (rst_n),
    .execute_valid                 (execute_valid),
    .execute_alu_out               (execute_alu_out),
    .execute_register_b_data       (execute_register_b_data),
    .execute_dest_register_address (execute_dest_register_address),
    .execute_mem_read_ctrl         (execute_mem_read_ctrl),
    .execute_mem_write_ctrl        (execute_mem_write_ctrl),
    .execute_register_write_ctrl   (execute_register_write_ctrl),
    .dmem_req                      (dmem_req),
    .dmem_we                       (dmem_we),
    .dmem_addr                     (dmem_addr),
    .dmem_wdata                    (dmem_wdata),
    .dmem_ack                      (dmem_ack),
    .dmem_rdata                    (dmem_rdata),
    .back_valid                    (back_valid),
    .back_data                     (back_data),
    .back_dest_address             (back_dest_address),
    .back_register_write_ctrl      (back_register_write_ctrl),
    .memory_stall_ctrl             (memory_stall_ctrl),
    .mem_fault                     (mem_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One op plus what must come out of it.
  typedef struct {
    logic        v, rd, wr, wctrl;
    logic [31:0] alu, b;
    logic [4:0]  dest;
    int          lat;
    logic [31:0] rdata;
    logic        x_mem, x_we;
    int          x_cycles;
    logic        x_fault, x_bv, x_wctrl, x_chk_data;
    logic [31:0] x_data;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic v, rd, wr, wctrl, input logic [31:0] alu, b,
                              input logic [4:0] dest, input int lat, input logic [31:0] rdata,
                              input logic x_mem, x_we, input int x_cycles,
                              input logic x_fault, x_bv, x_wctrl, x_chk_data,
                              input logic [31:0] x_data);
    vec_t t;
    t.v = v; t.rd = rd; t.wr = wr; t.wctrl = wctrl; t.alu = alu; t.b = b;
    t.dest = dest; t.lat = lat; t.rdata = rdata; t.x_mem = x_mem; t.x_we = x_we;
    t.x_cycles = x_cycles; t.x_fault = x_fault; t.x_bv = x_bv; t.x_wctrl = x_wctrl;
    t.x_chk_data = x_chk_data; t.x_data = x_data;
    return t;
  endfunction

  // Reference model: outcome of one op from the block's documented rules.
  function automatic vec_t model(input vec_t t);
    vec_t r = t;
    r.x_mem      = t.v && (t.rd || t.wr);
    r.x_we       = t.wr;
    r.x_fault    = r.x_mem && (t.lat > TIMEOUT);
    r.x_cycles   = !r.x_mem ? 0 : (r.x_fault ? TIMEOUT : t.lat);
    r.x_bv       = t.v;
    r.x_wctrl    = t.v && t.wctrl && !r.x_fault && !(r.x_mem && t.wr);
    r.x_chk_data = t.v && !r.x_fault && !(r.x_mem && t.wr);
    r.x_data     = r.x_mem ? t.rdata : t.alu;
    return r;
  endfunction

  task automatic run_op(input vec_t t);
    execute_valid                 = t.v;
    execute_mem_read_ctrl         = t.rd;
    execute_mem_write_ctrl        = t.wr;
    execute_register_write_ctrl   = t.wctrl;
    execute_alu_out               = t.alu;
    execute_register_b_data       = t.b;
    execute_dest_register_address = t.dest;
    dmem_ack                      = 1'b0;
    #1;
    chk("stall_accept", 32'(memory_stall_ctrl), 32'(t.x_mem));
    step();
    if (!t.x_mem) begin
      chk("alu_bv", 32'(back_valid), 32'(t.x_bv));
      chk("alu_req", 32'(dmem_req), 32'd0);
      if (t.x_bv) begin
        chk("alu_data", back_data, t.x_data);
        chk("alu_dest", 32'(back_dest_address), 32'(t.dest));
        chk("alu_wctrl", 32'(back_register_write_ctrl), 32'(t.x_wctrl));
      end
    end else begin
      chk("req_rise", 32'(dmem_req), 32'd1);
      chk("req_we", 32'(dmem_we), 32'(t.x_we));
      chk("req_addr", dmem_addr, t.alu);
      chk("req_wdata", dmem_wdata, t.b);
      chk("req_bv", 32'(back_valid), 32'd0);
      for (int k = 1; k <= TIMEOUT; k++) begin
        execute_valid                 = 1'($urandom);
        execute_mem_read_ctrl         = 1'($urandom);
        execute_mem_write_ctrl        = 1'($urandom);
        execute_register_write_ctrl   = 1'($urandom);
        execute_alu_out               = $urandom;
        execute_register_b_data       = $urandom;
        execute_dest_register_address = 5'($urandom);
        dmem_ack                      = (k == t.lat);
        dmem_rdata                    = (k == t.lat) ? t.rdata : $urandom;
        #1;
        chk("stall_wait", 32'(memory_stall_ctrl), 32'd1);
        step();
        if (k == t.x_cycles) begin
          chk("end_bv", 32'(back_valid), 32'd1);
          chk("end_fault", 32'(mem_fault), 32'(t.x_fault));
          chk("end_wctrl", 32'(back_register_write_ctrl), 32'(t.x_wctrl));
          chk("end_req", 32'(dmem_req), 32'd0);
          if (!t.x_fault) chk("end_dest", 32'(back_dest_address), 32'(t.dest));
          if (t.x_chk_data) chk("end_data", back_data, t.x_data);
          break;
        end
        chk("wait_req", 32'(dmem_req), 32'd1);
        chk("wait_addr", dmem_addr, t.alu);
        chk("wait_wdata", dmem_wdata, t.b);
        chk("wait_we", 32'(dmem_we), 32'(t.x_we));
        chk("wait_bv", 32'(back_valid), 32'd0);
        chk("wait_fault", 32'(mem_fault), 32'd0);
      end
    end
    dmem_ack      = 1'b0;
    execute_valid = 1'b0;
    step();
    chk("post_bv", 32'(back_valid), 32'd0);
    chk("post_fault", 32'(mem_fault), 32'd0);
    chk("post_wctrl", 32'(back_register_write_ctrl), 32'd0);
    chk("post_req", 32'(dmem_req), 32'd0);
    if (t.x_chk_data) chk("post_hold", back_data, t.x_data);
  endtask

  vec_t tbl[9];
  vec_t r;

  initial begin
    rst_n                         = 1'b0;
    execute_valid                 = 1'b1;
    execute_mem_read_ctrl         = 1'b1;
    execute_mem_write_ctrl        = 1'b0;
    execute_register_write_ctrl   = 1'b1;
    execute_alu_out               = 32'h40;
    execute_register_b_data       = 32'h99;
    execute_dest_register_address = 5'd7;
    dmem_ack                      = 1'b0;
    dmem_rdata                    = '0;

    // Reset state, with a memory op present at the inputs and a clock edge passing.
    #12;
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_bv", 32'(back_valid), 32'd0);
    chk("rst_data", back_data, 32'd0);
    chk("rst_stall", 32'(memory_stall_ctrl), 32'd0);
    chk("rst_fault", 32'(mem_fault), 32'd0);
    execute_valid = 1'b0;
    rst_n         = 1'b1;

    // Ack while idle is ignored.
    dmem_ack = 1'b1;
    step();
    chk("idle_ack_bv", 32'(back_valid), 32'd0);
    chk("idle_ack_req", 32'(dmem_req), 32'd0);
    chk("idle_ack_fault", 32'(mem_fault), 32'd0);
    dmem_ack = 1'b0;

    //          v   rd  wr  wc  alu           b             dest lat rdata          mem we  cyc fl  bv  wc  cd  data
    tbl[0] = mk(1, 0, 0, 1, 32'h0000_0055, 32'h0,        3,  0,  32'h0,         0, 0, 0,  0, 1, 1, 1, 32'h55);
    tbl[1] = mk(1, 1, 0, 1, 32'h0000_0010, 32'h0,        5,  3,  32'hDEAD_BEEF, 1, 0, 3,  0, 1, 1, 1, 32'hDEAD_BEEF);
    tbl[2] = mk(1, 1, 1, 1, 32'h0000_0020, 32'h1234,     6,  1,  32'h0,         1, 1, 1,  0, 1, 0, 0, 32'h0);
    tbl[3] = mk(1, 1, 0, 1, 32'h0000_0030, 32'h0,        9,  99, 32'h0,         1, 0, 16, 1, 1, 0, 0, 32'h0);
    tbl[4] = mk(1, 1, 0, 1, 32'h0000_0034, 32'h0,        10, 16, 32'hCAFE_F00D, 1, 0, 16, 0, 1, 1, 1, 32'hCAFE_F00D);
    tbl[5] = mk(0, 1, 0, 1, 32'h0000_0044, 32'h0,        11, 1,  32'h0,         0, 0, 0,  0, 0, 0, 0, 32'h0);
    tbl[6] = mk(1, 0, 0, 0, 32'hFFFF_FFFF, 32'h0,        31, 0,  32'h0,         0, 0, 0,  0, 1, 0, 1, 32'hFFFF_FFFF);
    tbl[7] = mk(1, 0, 1, 0, 32'h0000_0100, 32'hA5A5_5A5A, 2, 15, 32'h0,         1, 1, 15, 0, 1, 0, 0, 32'h0);
    tbl[8] = mk(1, 1, 0, 0, 32'h0000_0200, 32'h0,        4,  2,  32'h0BAD_1DEA, 1, 0, 2,  0, 1, 0, 1, 32'h0BAD_1DEA);
    foreach (tbl[i]) run_op(tbl[i]);

    // Reset two cycles into a wait, then a late ack that must be ignored.
    r = mk(1, 1, 0, 1, 32'h50, 32'h0, 8, 99, 32'h0, 1, 0, 16, 1, 1, 0, 0, 32'h0);
    execute_valid = r.v; execute_mem_read_ctrl = r.rd; execute_mem_write_ctrl = r.wr;
    execute_alu_out = r.alu; execute_dest_register_address = r.dest;
    step();
    execute_valid = 1'b0;
    step();
    step();
    chk("pre_rst_req", 32'(dmem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(dmem_req), 32'd0);
    chk("arst_stall", 32'(memory_stall_ctrl), 32'd0);
    chk("arst_addr", dmem_addr, 32'd0);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h1111_2222;
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("arst_late_bv", 32'(back_valid), 32'd0);
    chk("arst_late_fault", 32'(mem_fault), 32'd0);
    chk("arst_late_req", 32'(dmem_req), 32'd0);
    dmem_ack = 1'b0;

    // First op accepted on the first edge after release.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    run_op(mk(1, 0, 0, 1, 32'h0000_0077, 32'h0, 12, 0, 32'h0, 0, 0, 0, 0, 1, 1, 1, 32'h77));

    // Randomized ops against the model.
    for (int n = 0; n < 60; n++) begin
      vec_t t;
      int kind;
      kind = int'($urandom_range(0, 4));
      t = mk(1, 0, 0, 1'($urandom), $urandom, $urandom, 5'($urandom),
             int'($urandom_range(1, TIMEOUT + 3)), $urandom, 0, 0, 0, 0, 0, 0, 0, 32'h0);
      case (kind)
        0: ;
        1: t.rd = 1'b1;
        2: t.wr = 1'b1;
        3: begin t.rd = 1'b1; t.wr = 1'b1; end
        default: begin t.v = 1'b0; t.rd = 1'($urandom); t.wr = 1'($urandom); end
      endcase
      run_op(model(t));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
